// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// Holds the per-channel FSM state encoding and the default debounce window.
// No logic; imported by the channel and top modules.
package sw_debounce_pkg;

    // 10 ms at 25 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } db_state_e;

endpackage

// File: rtl/debounce_ch.sv
// Single-channel switch debouncer: 2-flop synchronizer, hold-time FSM, press/release pulses, LED toggle.
// Latency: a clean input step reaches sw_level and the pulse DEBOUNCE_CYCLES+1 edges after it is first sampled.
// No backpressure: pulses are single-cycle and unconditional.
module debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_level,
    output logic sw_press,
    output logic sw_release,
    output logic led_toggle
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    // Entry into WAIT_* already consumed one matching sample, so the count
    // stops one short of the window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;

    logic             sw_sync;
    logic             cnt_done;

    assign sw_sync  = sync_q[1];
    assign cnt_done = (cnt_q == CNT_LAST);

    // Synchronizer shift: raw pad level enters bit 0, bit 1 feeds the FSM.
    always_comb begin
        sync_d = {sync_q[0], sw_in};
    end

    // Debounce FSM: a new level must persist through the whole window; any
    // reversion while waiting drops back silently. Counter never wraps since
    // the FSM leaves WAIT_* when it reaches CNT_LAST.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_STABLE_LO: begin
                if (sw_sync) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!sw_sync) begin
                    state_d = ST_STABLE_LO;
                end else if (cnt_done) begin
                    state_d = ST_STABLE_HI;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE_HI: begin
                if (!sw_sync) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (sw_sync) begin
                    state_d = ST_STABLE_HI;
                end else if (cnt_done) begin
                    state_d   = ST_STABLE_LO;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // LED flips on the cycle the press pulse is high; release leaves it alone.
    always_comb begin
        toggle_d = toggle_q ^ press_q;
    end

    // All channel state; reset abandons any count in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b00;
            state_q   <= ST_STABLE_LO;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign sw_level   = (state_q == ST_STABLE_HI) || (state_q == ST_WAIT_LO);
    assign sw_press   = press_q;
    assign sw_release = release_q;
    assign led_toggle = toggle_q;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with press/release pulses and per-channel LED toggle.
// Latency: DEBOUNCE_CYCLES+1 edges from first sampling of a clean step to level/pulse.
// No backpressure: channels are fully independent and free-running.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] SW_IN,
    output logic [NUM_CH-1:0] SW_LEVEL,
    output logic [NUM_CH-1:0] SW_PRESS,
    output logic [NUM_CH-1:0] SW_RELEASE,
    output logic [NUM_CH-1:0] LED_TOGGLE
);

    // One independent debouncer per switch.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (CLK),
            .rst       (RST),
            .sw_in     (SW_IN[i]),
            .sw_level  (SW_LEVEL[i]),
            .sw_press  (SW_PRESS[i]),
            .sw_release(SW_RELEASE[i]),
            .led_toggle(LED_TOGGLE[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] sw_level, sw_press, sw_release, led_toggle;

    int vectors     = 0;
    int miscompares = 0;

    sw_debounce #(
        .NUM_CH         (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .SW_IN     (sw_in),
        .SW_LEVEL  (sw_level),
        .SW_PRESS  (sw_press),
        .SW_RELEASE(sw_release),
        .LED_TOGGLE(led_toggle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rel, input logic [3:0] led);
        check({tag, ".level"},   sw_level,   lvl);
        check({tag, ".press"},   sw_press,   prs);
        check({tag, ".release"}, sw_release, rel);
        check({tag, ".led"},     led_toggle, led);
    endtask

    // n edges with no output activity
    task automatic idle_check(input string tag, input int n, input logic [3:0] lvl, input logic [3:0] led);
        for (int k = 0; k < n; k++) begin
            tick();
            check_all(tag, lvl, 4'b0000, 4'b0000, led);
        end
    endtask

    // Input already changed before edge 0: quiet through edge 8, accepted after edge 9,
    // pulse gone and LED updated after edge 10.
    task automatic expect_accept(input string tag, input logic [3:0] old_lvl,
                                 input logic [3:0] new_lvl, input logic [3:0] led_old);
        logic [3:0] prs, rel;
        prs = new_lvl & ~old_lvl;
        rel = old_lvl & ~new_lvl;
        idle_check({tag, ".wait"}, 9, old_lvl, led_old);
        tick();
        check_all({tag, ".accept"}, new_lvl, prs, rel, led_old);
        tick();
        check_all({tag, ".after"}, new_lvl, 4'b0000, 4'b0000, led_old ^ prs);
    endtask

    initial begin
        // Reset state
        rst   = 1'b1;
        sw_in = 4'b0000;
        tick();
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        idle_check("idle20", 20, 4'b0000, 4'b0000);

        // Clean press and release on ch0
        sw_in = 4'b0001;
        expect_accept("press0", 4'b0000, 4'b0001, 4'b0000);
        sw_in = 4'b0000;
        expect_accept("release0", 4'b0001, 4'b0000, 4'b0001);

        // 5-cycle pulse on ch1 rejected
        sw_in = 4'b0010;
        idle_check("short1.hi", 5, 4'b0000, 4'b0001);
        sw_in = 4'b0000;
        idle_check("short1.lo", 12, 4'b0000, 4'b0001);

        // 7-cycle pulse on ch3: one sample short of the window, rejected
        sw_in = 4'b1000;
        idle_check("edge3.hi", 7, 4'b0000, 4'b0001);
        sw_in = 4'b0000;
        idle_check("edge3.lo", 12, 4'b0000, 4'b0001);

        // Bounce 1,0,1,0 on ch2 then steady 1: one press timed from the last rise
        sw_in = 4'b0100; idle_check("bounce", 1, 4'b0000, 4'b0001);
        sw_in = 4'b0000; idle_check("bounce", 1, 4'b0000, 4'b0001);
        sw_in = 4'b0100; idle_check("bounce", 1, 4'b0000, 4'b0001);
        sw_in = 4'b0000; idle_check("bounce", 1, 4'b0000, 4'b0001);
        sw_in = 4'b0100;
        expect_accept("bounce2", 4'b0000, 4'b0100, 4'b0001);
        idle_check("bounce2.hold", 5, 4'b0100, 4'b0101);

        // Reset clears everything, including LED toggles and held level
        rst = 1'b1;
        #1;
        check_all("reset2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        sw_in = 4'b0000;
        tick();
        rst = 1'b0;
        idle_check("reset2.idle", 4, 4'b0000, 4'b0000);

        // All channels together
        sw_in = 4'b1111;
        expect_accept("all.press", 4'b0000, 4'b1111, 4'b0000);
        idle_check("all.hold", 9, 4'b1111, 4'b1111);
        sw_in = 4'b0000;
        expect_accept("all.release", 4'b1111, 4'b0000, 4'b1111);

        // Reset mid-count (counter=4 after edge 6) with switch held high
        sw_in = 4'b0001;
        idle_check("midrst.count", 7, 4'b0000, 4'b1111);
        rst = 1'b1;
        #1;
        check_all("midrst.async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_all("midrst.held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
        expect_accept("midrst.press", 4'b0000, 4'b0001, 4'b0000);
        idle_check("midrst.single", 6, 4'b0001, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz): consecutive cycles an input must hold a new level before it is accepted; legal range 2..2^24.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 SW_IN  input  NUM_CH  raw switch levels from input pads; asynchronous to CLK; 1 = pressed.
REQ-006 SW_LEVEL  output  NUM_CH  debounced level per channel.
REQ-007 SW_PRESS  output  NUM_CH  one-cycle pulse on accepted 0->1 transition.
REQ-008 SW_RELEASE  output  NUM_CH  one-cycle pulse on accepted 1->0 transition.
REQ-009 LED_TOGGLE  output  NUM_CH  per-channel toggle state; inverts on each SW_PRESS; drives LED output pads.

Function
REQ-010 Each SW_IN bit shall pass through a 2-flop synchronizer before any other logic; no other logic samples SW_IN directly.
REQ-011 Each channel shall run an independent FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO: sync=1 -> WAIT_HI, counter cleared to 0; otherwise stay.
REQ-013 WAIT_HI: sync=0 -> STABLE_LO (glitch rejected, no pulse); sync=1 and counter=DEBOUNCE_CYCLES-2 -> STABLE_HI; otherwise counter+1.
REQ-014 STABLE_HI and WAIT_LO: mirror of REQ-012/013 with levels inverted.
REQ-015 SW_LEVEL shall be 1 exactly when the FSM is in STABLE_HI or WAIT_LO.
REQ-016 SW_PRESS shall be registered and high for exactly the one cycle after the WAIT_HI->STABLE_HI transition; SW_RELEASE likewise for WAIT_LO->STABLE_LO.
REQ-017 Latency: a clean step on SW_IN set up before edge 0 shall appear on SW_LEVEL and the matching pulse after edge 1+DEBOUNCE_CYCLES (2 synchronizer cycles plus DEBOUNCE_CYCLES-1 counting cycles).
REQ-018 A pulse on SW_IN shorter than DEBOUNCE_CYCLES-1 synchronized cycles shall produce no change on any output.
REQ-019 Counter width shall be clog2(DEBOUNCE_CYCLES); the counter shall never wrap; it saturates by FSM exit.
REQ-020 LED_TOGGLE[i] shall invert on the cycle SW_PRESS[i] is high, visible the following cycle; SW_RELEASE shall not affect it.
REQ-021 SW_PRESS[i] and SW_RELEASE[i] shall never be high in the same cycle; different channels may pulse simultaneously, with no interaction.

Reset
REQ-022 RST high shall force asynchronously: synchronizers 0, FSM STABLE_LO, counters 0, SW_LEVEL 0, SW_PRESS 0, SW_RELEASE 0, LED_TOGGLE 0.
REQ-023 Reset asserted mid-debounce shall abandon the count; no pulse shall be emitted for that transition.
REQ-024 A switch held pressed through reset release shall be accepted as a press DEBOUNCE_CYCLES+1 cycles after release, producing one SW_PRESS.

Structure
REQ-025 Package sw_debounce_pkg shall hold the FSM state enum and the default DEBOUNCE_CYCLES constant.
REQ-026 One sub-module, debounce_ch, shall implement a single channel (synchronizer, FSM, counter, pulses, toggle) and be instantiated NUM_CH times by generate.

Verification (DEBOUNCE_CYCLES=8, NUM_CH=4)
REQ-027 Reset, SW_IN=4'b0000 held for 20 cycles -> all outputs 0 throughout.
REQ-028 SW_IN[0] 0->1 before edge 0, held -> SW_LEVEL[0]=1 and SW_PRESS[0] one cycle after edge 9; LED_TOGGLE[0]=1 the cycle after.
REQ-029 SW_IN[1] high for 5 cycles, then low -> no output change on any channel.
REQ-030 SW_IN[2] bouncing 1,0,1,0,1 (one cycle each), then steady 1 -> a single SW_PRESS[2], 8 synchronized cycles after the last 0->1.
REQ-031 SW_IN=4'b1111 simultaneously, then 4'b0000 after 20 cycles -> 4'b1111 press pulses in the same cycle, then 4'b1111 release pulses; LED_TOGGLE=4'b1111.
REQ-032 RST pulsed at counter=4 during a press -> outputs 0 immediately; SW_IN still high -> one SW_PRESS 9 cycles after RST release.
